// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the debug UART receive path.
// Holds no logic, so it adds no latency and applies no backpressure.
package uart_pkg;

    typedef enum logic [1:0] {
        BYTE_IDLE,
        BYTE_START,
        BYTE_DATA,
        BYTE_STOP
    } byte_state_t;

    typedef enum logic [1:0] {
        PARSE_WAIT_SYNC,
        PARSE_CMD,
        PARSE_DATA,
        PARSE_CHK
    } parse_state_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] word;
    } frame_t;

    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN    = 7;

    function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 deserialiser: 2-FF sync, start/data/stop sampling at bit centres; byte valid one cycle after the stop sample.
// No backpressure: each byte is a single-cycle pulse; a low stop bit raises a same-cycle framing strobe.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_vld,
    output logic       o_ferr,
    output logic       o_fall,
    output logic       o_busy
);

    localparam int unsigned   CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync_q;
    byte_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic          r_wait_high;
    logic [7:0]    r_data;
    logic          r_data_vld;

    logic w_rx;
    logic w_fall;
    logic w_tick;

    assign w_rx   = r_sync2;
    assign w_fall = r_sync_q & ~r_sync2;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_q <= 1'b1;
        end else begin
            r_sync1  <= i_rx;
            r_sync2  <= r_sync1;
            r_sync_q <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= BYTE_IDLE;
            r_cnt       <= '0;
            r_bitn      <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
            r_data      <= '0;
            r_data_vld  <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            case (r_state)
                BYTE_IDLE: begin
                    // After a bad stop bit the line must go high before a new start is trusted.
                    if (r_wait_high) begin
                        if (w_rx) begin
                            r_wait_high <= 1'b0;
                        end
                    end else if (w_fall) begin
                        r_state <= BYTE_START;
                        r_cnt   <= HALF_RELOAD;
                    end
                end
                BYTE_START: begin
                    if (w_tick) begin
                        if (w_rx) begin
                            r_state <= BYTE_IDLE;
                        end else begin
                            r_state <= BYTE_DATA;
                            r_cnt   <= FULL_RELOAD;
                            r_bitn  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BYTE_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= FULL_RELOAD;
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) begin
                            r_state <= BYTE_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BYTE_STOP: begin
                    if (w_tick) begin
                        r_state <= BYTE_IDLE;
                        if (w_rx) begin
                            r_data     <= r_shift;
                            r_data_vld <= 1'b1;
                        end else begin
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= BYTE_IDLE;
            endcase
        end
    end

    assign o_data     = r_data;
    assign o_data_vld = r_data_vld;
    assign o_ferr     = (r_state == BYTE_STOP) & w_tick & ~w_rx;
    assign o_fall     = w_fall;
    assign o_busy     = (r_state != BYTE_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Debug-UART command framer: SYNC,CMD,D0..D3,CHK -> cmd + 32-bit word; frame_valid/frame_err one cycle after the CHK byte.
// No backpressure: results are single-cycle pulses; framing, checksum and inter-byte timeout errors are counted (saturating).
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter logic [7:0]  SYNC         = SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        rx_pin_in,
    output logic [7:0]  rx_data,
    output logic        rx_byte_valid,
    output logic [7:0]  frame_cmd,
    output logic [31:0] frame_word,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned   DIV           = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned   TO_CYCLES     = TIMEOUT_BITS * DIV;
    localparam int unsigned   TW            = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST       = TW'(TO_CYCLES - 1);
    localparam int unsigned   PAYLOAD_BYTES = FRAME_LEN - 3;
    localparam logic [1:0]    LAST_IDX      = 2'(PAYLOAD_BYTES - 1);

    logic [7:0] w_byte;
    logic       w_byte_vld;
    logic       w_ferr;
    logic       w_fall;
    logic       w_busy;
    logic       w_to_run;
    logic       w_to_expire;
    logic       w_chk_bad;
    logic       w_err_evt;

    parse_state_t  r_pstate;
    logic [1:0]    r_idx;
    logic [7:0]    r_chk;
    frame_t        r_acc;
    frame_t        r_frame;
    logic          r_frame_vld;
    logic          r_frame_err;
    logic [7:0]    r_err_cnt;
    logic [TW-1:0] r_to_cnt;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx_byte (
        .i_clk      (CLK100MHZ),
        .i_rst_n    (rst_n),
        .i_rx       (rx_pin_in),
        .o_data     (w_byte),
        .o_data_vld (w_byte_vld),
        .o_ferr     (w_ferr),
        .o_fall     (w_fall),
        .o_busy     (w_busy)
    );

    // The inter-byte timer only runs while a frame is open and the line is quiet.
    assign w_to_run    = (r_pstate != PARSE_WAIT_SYNC) & ~w_busy & ~w_fall;
    assign w_to_expire = w_to_run & (r_to_cnt == TO_LAST);
    assign w_chk_bad   = w_byte_vld & (r_pstate == PARSE_CHK) & (w_byte != r_chk);
    assign w_err_evt   = w_ferr | w_to_expire | w_chk_bad;

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_run || w_to_expire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_pstate    <= PARSE_WAIT_SYNC;
            r_idx       <= '0;
            r_chk       <= '0;
            r_acc       <= '0;
            r_frame     <= '0;
            r_frame_vld <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_frame_vld <= 1'b0;
            r_frame_err <= w_err_evt;
            if (w_err_evt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_ferr || w_to_expire) begin
                r_pstate <= PARSE_WAIT_SYNC;
            end else if (w_byte_vld) begin
                case (r_pstate)
                    PARSE_WAIT_SYNC: begin
                        if (w_byte == SYNC) begin
                            r_pstate <= PARSE_CMD;
                        end
                    end
                    PARSE_CMD: begin
                        r_acc.cmd <= w_byte;
                        r_chk     <= w_byte;
                        r_idx     <= '0;
                        r_pstate  <= PARSE_DATA;
                    end
                    PARSE_DATA: begin
                        r_acc.word <= {r_acc.word[23:0], w_byte};
                        r_chk      <= r_chk ^ w_byte;
                        r_idx      <= r_idx + 2'd1;
                        if (r_idx == LAST_IDX) begin
                            r_pstate <= PARSE_CHK;
                        end
                    end
                    PARSE_CHK: begin
                        r_pstate <= PARSE_WAIT_SYNC;
                        if (!w_chk_bad) begin
                            r_frame     <= r_acc;
                            r_frame_vld <= 1'b1;
                        end
                    end
                    default: r_pstate <= PARSE_WAIT_SYNC;
                endcase
            end
        end
    end

    assign rx_data       = w_byte;
    assign rx_byte_valid = w_byte_vld;
    assign frame_cmd     = r_frame.cmd;
    assign frame_word    = r_frame.word;
    assign frame_valid   = r_frame_vld;
    assign frame_err     = r_frame_err;
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx at a reduced bit period (DIV=10): vector table, hand-built corner sequences, random stream vs model.
`timescale 1ns/1ps
module tb_uart_frame_rx;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          DIV      = 10;
    localparam int          TO_BITS  = 20;
    localparam logic [7:0]  SYNC     = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_byte_valid;
    logic [7:0]  frame_cmd;
    logic [31:0] frame_word;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .SYNC         (SYNC),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .CLK100MHZ     (clk),
        .rst_n         (rst_n),
        .rx_pin_in     (rx),
        .rx_data       (rx_data),
        .rx_byte_valid (rx_byte_valid),
        .frame_cmd     (frame_cmd),
        .frame_word    (frame_word),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .err_cnt       (err_cnt)
    );

    int n_vec;
    int n_miss;
    int n_bytes;
    int n_fv;
    int n_fe;
    logic [39:0] fv_q[$];

    always @(negedge clk) begin
        if (rx_byte_valid) n_bytes++;
        if (frame_valid) begin
            n_fv++;
            fv_q.push_back({frame_cmd, frame_word});
        end
        if (frame_err) n_fe++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * DIV) @(negedge clk);
    endtask

    // Line is left at the stop level, so a low stop bit keeps the line low.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] c, input logic [31:0] w);
        return c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    task automatic send_frame(input logic [7:0] c, input logic [31:0] w, input logic [7:0] flip);
        send_byte(SYNC, 1'b1);
        send_byte(c, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
        send_byte(xsum(c, w) ^ flip, 1'b1);
    endtask

    typedef struct {
        logic [0:8][7:0] seq;
        int              nb;
        int              exp_fv;
        int              exp_fe;
        logic [7:0]      exp_cmd;
        logic [31:0]     exp_word;
        int              exp_err;
    } vec_t;

    vec_t        tbl[6];
    int          fv0, fe0, b0, lat, t_to, exp_bad, idx;
    logic [7:0]  strm[$];
    logic [39:0] exp_q[$];
    logic [7:0]  c, nz, flip;
    logic [31:0] w;

    initial begin
        tbl[0] = '{seq:{8'hA5,8'h01,8'h12,8'h34,8'h56,8'h78,8'h09,8'h00,8'h00}, nb:7,
                   exp_fv:1, exp_fe:0, exp_cmd:8'h01, exp_word:32'h12345678, exp_err:0};
        tbl[1] = '{seq:{8'hA5,8'h01,8'h12,8'h34,8'h56,8'h78,8'h08,8'h00,8'h00}, nb:7,
                   exp_fv:0, exp_fe:1, exp_cmd:8'h01, exp_word:32'h12345678, exp_err:1};
        tbl[2] = '{seq:{8'h00,8'hFF,8'hA5,8'h02,8'hDE,8'hAD,8'hBE,8'hEF,8'h20}, nb:9,
                   exp_fv:1, exp_fe:0, exp_cmd:8'h02, exp_word:32'hDEADBEEF, exp_err:1};
        tbl[3] = '{seq:{8'hA5,8'hA5,8'hA5,8'hA5,8'hA5,8'hA5,8'hA5,8'h00,8'h00}, nb:7,
                   exp_fv:1, exp_fe:0, exp_cmd:8'hA5, exp_word:32'hA5A5A5A5, exp_err:1};
        tbl[4] = '{seq:{8'hA5,8'hFF,8'h00,8'h00,8'h00,8'h00,8'hFF,8'h00,8'h00}, nb:7,
                   exp_fv:1, exp_fe:0, exp_cmd:8'hFF, exp_word:32'h00000000, exp_err:1};
        tbl[5] = '{seq:{8'hA5,8'h10,8'h00,8'h00,8'h00,8'h01,8'h10,8'h00,8'h00}, nb:7,
                   exp_fv:0, exp_fe:1, exp_cmd:8'hFF, exp_word:32'h00000000, exp_err:2};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_byte_valid", rx_byte_valid, 0);
        chk("reset_cmd", frame_cmd, 0);
        chk("reset_word", frame_word, 0);
        chk("reset_fv", frame_valid, 0);
        chk("reset_fe", frame_err, 0);
        chk("reset_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        idle_bits(2);

        for (int v = 0; v < 6; v++) begin
            fv0 = n_fv;
            fe0 = n_fe;
            for (int j = 0; j < tbl[v].nb; j++) send_byte(tbl[v].seq[j], 1'b1);
            idle_bits(3);
            chk($sformatf("vec%0d_fv", v), n_fv - fv0, tbl[v].exp_fv);
            chk($sformatf("vec%0d_fe", v), n_fe - fe0, tbl[v].exp_fe);
            chk($sformatf("vec%0d_cmd", v), frame_cmd, tbl[v].exp_cmd);
            chk($sformatf("vec%0d_word", v), frame_word, tbl[v].exp_word);
            chk($sformatf("vec%0d_err_cnt", v), err_cnt, tbl[v].exp_err);
        end

        // Byte latency: two sync stages plus edge detect, then half a bit and nine bits.
        fe0 = n_fe;
        lat = 0;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                for (int n = 1; n <= 12 * DIV; n++) begin
                    @(negedge clk);
                    if (rx_byte_valid && lat == 0) lat = n;
                end
            end
        join
        idle_bits(1);
        chk("byte_latency", lat, 3 + DIV / 2 + 9 * DIV);
        chk("byte_data", rx_data, 8'h3C);
        chk("stray_byte_no_err", n_fe - fe0, 0);

        b0  = n_bytes;
        fe0 = n_fe;
        rx  = 1'b0;
        repeat (DIV / 2 - 3) @(negedge clk);
        idle_bits(3);
        chk("glitch_no_byte", n_bytes - b0, 0);
        chk("glitch_no_err", n_fe - fe0, 0);

        b0  = n_bytes;
        fe0 = n_fe;
        send_byte(8'h55, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        idle_bits(2);
        chk("ferr_no_byte", n_bytes - b0, 0);
        chk("ferr_pulse", n_fe - fe0, 1);
        chk("ferr_err_cnt", err_cnt, 3);
        fv0 = n_fv;
        send_frame(8'h77, 32'h00C0FFEE, 8'h00);
        idle_bits(2);
        chk("ferr_recover_fv", n_fv - fv0, 1);
        chk("ferr_recover_word", frame_word, 32'h00C0FFEE);

        send_byte(SYNC, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        fe0  = n_fe;
        t_to = 0;
        for (int n = 1; n <= 25 * DIV; n++) begin
            @(negedge clk);
            if (frame_err && t_to == 0) t_to = n;
        end
        chk_range("timeout_at", t_to, 19 * DIV, 20 * DIV + DIV / 2);
        chk("timeout_pulse", n_fe - fe0, 1);
        chk("timeout_err_cnt", err_cnt, 4);
        fv0 = n_fv;
        send_frame(8'hC3, 32'h0F1E2D3C, 8'h00);
        idle_bits(2);
        chk("timeout_recover_fv", n_fv - fv0, 1);
        chk("timeout_recover_cmd", frame_cmd, 8'hC3);
        chk("timeout_recover_word", frame_word, 32'h0F1E2D3C);

        send_byte(SYNC, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_cmd", frame_cmd, 0);
        chk("midrst_word", frame_word, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_pulses", {rx_byte_valid, frame_valid, frame_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(3);
        fv0 = n_fv;
        fe0 = n_fe;
        send_frame(8'h5A, 32'h8BADF00D, 8'h00);
        idle_bits(2);
        chk("midrst_next_fv", n_fv - fv0, 1);
        chk("midrst_next_cmd", frame_cmd, 8'h5A);
        chk("midrst_next_word", frame_word, 32'h8BADF00D);
        chk("midrst_next_no_err", n_fe - fe0, 0);

        strm.delete();
        for (int f = 0; f < 20; f++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                nz = 8'($urandom_range(0, 255));
                strm.push_back((nz == SYNC) ? 8'h00 : nz);
            end
            c    = 8'($urandom_range(0, 255));
            w    = $urandom;
            flip = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            strm.push_back(SYNC);
            strm.push_back(c);
            for (int i = 3; i >= 0; i--) strm.push_back(w[i*8 +: 8]);
            strm.push_back(xsum(c, w) ^ flip);
        end

        exp_q.delete();
        exp_bad = 0;
        idx     = 0;
        while (idx < strm.size()) begin
            if (strm[idx] != SYNC) begin
                idx++;
            end else if (idx + 6 < strm.size()) begin
                c = strm[idx + 1];
                w = {strm[idx + 2], strm[idx + 3], strm[idx + 4], strm[idx + 5]};
                if (strm[idx + 6] == xsum(c, w)) exp_q.push_back({c, w});
                else exp_bad++;
                idx += 7;
            end else begin
                idx = strm.size();
            end
        end

        fv_q.delete();
        fe0 = n_fe;
        foreach (strm[i]) begin
            send_byte(strm[i], 1'b1);
            idle_bits($urandom_range(0, 2));
        end
        idle_bits(3);
        chk("rand_frame_count", fv_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < fv_q.size(); k++) begin
            chk($sformatf("rand_frame%0d", k), fv_q[k], exp_q[k]);
        end
        chk("rand_err_pulses", n_fe - fe0, exp_bad);
        chk("rand_err_cnt", err_cnt, exp_bad);

        fe0 = n_fe;
        for (int k = 0; k < 256; k++) begin
            send_byte(8'h55, 1'b0);
            idle_bits(1);
        end
        idle_bits(1);
        chk("sat_err_pulses", n_fe - fe0, 256);
        chk("sat_err_cnt", err_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
